// File: rtl/dram_test_pkg.sv
// dram_test_pkg: shared state type, default widths and the address-derived test pattern
package dram_test_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    // One 16-bit lane of the pattern: (a[15:0] + lane) ^ seed, wrapping mod 2^16.
    function automatic logic [15:0] pattern_lane(
        input logic [15:0] addr_lo,
        input logic [15:0] seed,
        input int          lane
    );
        return (addr_lo + 16'(lane)) ^ seed;
    endfunction

    // Full pattern word at the default data width.
    function automatic logic [DEF_DATA_W-1:0] pattern_word(
        input logic [15:0] addr_lo,
        input logic [15:0] seed
    );
        logic [DEF_DATA_W-1:0] w;
        for (int i = 0; i < DEF_DATA_W / 16; i++) begin
            w[16*i +: 16] = pattern_lane(addr_lo, seed, i);
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// dram_pattern_gen: combinational pattern word for one address, any multiple-of-16 width
module dram_pattern_gen
    import dram_test_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [15:0]       addr_lo,
    input  logic [15:0]       seed,
    output logic [DATA_W-1:0] data
);

    for (genvar i = 0; i < DATA_W / 16; i++) begin : g_lane
        assign data[16*i +: 16] = pattern_lane(addr_lo, seed, i);
    end

endmodule

// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: writes an address-derived pattern over a range, reads it back and counts mismatches
module dram_pattern_tester
    import dram_test_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   word_count,
    input  logic [15:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [31:0]         error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                first_err_valid,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_we,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic                wdata_valid,
    input  logic                wdata_ready,
    output logic [DATA_W/8-1:0] wdata_we,
    output logic [DATA_W-1:0]   wdata_data,
    input  logic                rdata_valid,
    output logic                rdata_ready,
    input  logic [DATA_W-1:0]   rdata_data
);

    localparam int CW = ADDR_W + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_addr, rd_cmd_addr, rd_chk_addr;
    logic [CW-1:0]     wc_q, wr_cnt, issued, returned;
    logic [OW-1:0]     outstanding;
    logic [15:0]       seed_q;
    logic              cmd_done, wd_done;
    logic              launch, cmd_hs, wd_hs, rd_hs, rd_issue, word_done, mismatch;
    logic [DATA_W-1:0] wr_pat, exp_pat;

    dram_pattern_gen #(.DATA_W(DATA_W)) u_wr_gen (
        .addr_lo(wr_addr[15:0]),
        .seed   (seed_q),
        .data   (wr_pat)
    );

    dram_pattern_gen #(.DATA_W(DATA_W)) u_exp_gen (
        .addr_lo(rd_chk_addr[15:0]),
        .seed   (seed_q),
        .data   (exp_pat)
    );

    assign launch    = start && (state == IDLE || state == DONE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign wd_hs     = wdata_valid && wdata_ready;
    assign rd_hs     = rdata_valid && rdata_ready;
    assign rd_issue  = cmd_hs && state == READ;
    // A side whose valid is high completes when its ready is high, so ready stands in for the handshake.
    assign word_done = state == WRITE && (cmd_done || cmd_ready) && (wd_done || wdata_ready);
    assign mismatch  = rdata_data != exp_pat;

    assign busy       = state == WRITE || state == READ;
    assign done       = state == DONE;
    assign pass       = done && error_count == '0;
    assign wdata_we   = {(DATA_W/8){wdata_valid}};
    assign wdata_data = state == WRITE ? wr_pat : '0;

    // Next state and native-port command/data strobes.
    always_comb begin
        state_nx    = state;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = '0;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_nx = word_count == '0 ? DONE : WRITE;
            end
            WRITE: begin
                cmd_valid   = !cmd_done;
                cmd_we      = 1'b1;
                cmd_addr    = wr_addr;
                wdata_valid = !wd_done;
                if (word_done && wr_cnt + CW'(1) == wc_q) state_nx = READ;
            end
            READ: begin
                cmd_valid   = issued < wc_q && outstanding < OW'(MAX_OUTSTANDING);
                cmd_addr    = rd_cmd_addr;
                rdata_ready = 1'b1;
                if (rdata_valid && returned + CW'(1) == wc_q) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and run parameters latched on an accepted start.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state  <= IDLE;
            wc_q   <= '0;
            seed_q <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                wc_q   <= {1'b0, word_count};
                seed_q <= seed;
            end
        end
    end

    // Write phase: sticky per-side done flags, advancing once both sides of a word have completed.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            wr_addr  <= '0;
            wr_cnt   <= '0;
            cmd_done <= 1'b0;
            wd_done  <= 1'b0;
        end else if (launch) begin
            wr_addr  <= base_addr;
            wr_cnt   <= '0;
            cmd_done <= 1'b0;
            wd_done  <= 1'b0;
        end else if (state == WRITE) begin
            cmd_done <= !word_done && (cmd_done || cmd_hs);
            wd_done  <= !word_done && (wd_done || wd_hs);
            if (word_done) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                wr_cnt  <= wr_cnt + CW'(1);
            end
        end
    end

    // Read issue side and the in-flight counter; an issue and a return in one cycle cancel out.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            rd_cmd_addr <= '0;
            issued      <= '0;
            outstanding <= '0;
        end else if (launch) begin
            rd_cmd_addr <= base_addr;
            issued      <= '0;
            outstanding <= '0;
        end else begin
            if (rd_issue) begin
                rd_cmd_addr <= rd_cmd_addr + ADDR_W'(1);
                issued      <= issued + CW'(1);
            end
            if (rd_issue != rd_hs) outstanding <= rd_issue ? outstanding + OW'(1) : outstanding - OW'(1);
        end
    end

    // Read return side: in-order compare, saturating error count and first failing address.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            rd_chk_addr     <= '0;
            returned        <= '0;
            error_count     <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else if (launch) begin
            rd_chk_addr     <= base_addr;
            returned        <= '0;
            error_count     <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else if (rd_hs) begin
            rd_chk_addr <= rd_chk_addr + ADDR_W'(1);
            returned    <= returned + CW'(1);
            if (mismatch) begin
                if (error_count != '1) error_count <= error_count + 32'd1;
                if (!first_err_valid) begin
                    first_err_addr  <= rd_chk_addr;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_pattern_tester.sv
// tb_dram_pattern_tester: directed scenarios against a behavioural native-port memory
module tb_dram_pattern_tester;

    logic         user_clk = 1'b0;
    logic         user_rst = 1'b1;
    logic         start = 1'b0;
    logic [23:0]  base_addr = '0;
    logic [23:0]  word_count = '0;
    logic [15:0]  seed = '0;
    logic         busy, done, pass, first_err_valid;
    logic [31:0]  error_count;
    logic [23:0]  first_err_addr, cmd_addr;
    logic         cmd_valid, cmd_we, wdata_valid, rdata_ready;
    logic         cmd_ready = 1'b0;
    logic         wdata_ready = 1'b0;
    logic         rdata_valid = 1'b0;
    logic [31:0]  wdata_we;
    logic [255:0] wdata_data;
    logic [255:0] rdata_data = '0;

    int checks = 0;
    int errors = 0;

    logic [255:0] mem [logic [23:0]];
    logic [23:0]  rq[$], wq[$], wlog[$], rlog[$];
    logic [255:0] dq[$];
    int           rdue[$];
    int           cyc = 0, lat = 1, cmd_stall = 0, wd_stall = 0, cmd_wait = 0, wd_wait = 0;
    int           outst = 0, max_outst = 0, n_wcmd = 0, n_wdata = 0, n_ret = 0, n_cv = 0;
    int           drop_err = 0, be_err = 0;
    bit           pend_c = 0, pend_w = 0, saw_limit = 0, flip_en = 0, c_hs, w_hs;
    logic [23:0]  flip_addr = '0;

    dram_pattern_tester dut (
        .user_clk       (user_clk),
        .user_rst       (user_rst),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .first_err_valid(first_err_valid),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .wdata_valid    (wdata_valid),
        .wdata_ready    (wdata_ready),
        .wdata_we       (wdata_we),
        .wdata_data     (wdata_data),
        .rdata_valid    (rdata_valid),
        .rdata_ready    (rdata_ready),
        .rdata_data     (rdata_data)
    );

    always #5 user_clk = ~user_clk;

    // Memory model: samples handshakes on the edge, drives ready/return data 1 ns later.
    initial begin
        logic [23:0]  ka;
        logic [255:0] kd;
        forever begin
            @(posedge user_clk);
            cyc++;
            if (user_rst) begin
                rq.delete(); rdue.delete(); wq.delete(); dq.delete();
                outst = 0; pend_c = 0; pend_w = 0; cmd_wait = 0; wd_wait = 0;
            end else begin
                if (cmd_valid) n_cv++;
                if (pend_c && cmd_valid && cmd_we) drop_err++;
                if (pend_w && wdata_valid) drop_err++;
                c_hs = cmd_valid && cmd_ready && cmd_we;
                w_hs = wdata_valid && wdata_ready;
                if (c_hs && !w_hs) begin if (pend_w) pend_w = 0; else pend_c = 1; end
                if (w_hs && !c_hs) begin if (pend_c) pend_c = 0; else pend_w = 1; end
                if (cmd_valid && cmd_we && !cmd_ready) cmd_wait++;
                else if (c_hs) cmd_wait = 0;
                if (wdata_valid && !wdata_ready) wd_wait++;
                else if (w_hs) wd_wait = 0;
                if (c_hs) begin wq.push_back(cmd_addr); wlog.push_back(cmd_addr); n_wcmd++; end
                if (cmd_valid && cmd_ready && !cmd_we) begin
                    rq.push_back(cmd_addr); rdue.push_back(cyc + lat); rlog.push_back(cmd_addr); outst++;
                end
                if (w_hs) begin
                    dq.push_back(wdata_data); n_wdata++;
                    if (wdata_we !== 32'hFFFF_FFFF) be_err++;
                end
                if (rdata_valid && rdata_ready) begin
                    void'(rq.pop_front()); void'(rdue.pop_front()); outst--; n_ret++;
                end
                while (wq.size() > 0 && dq.size() > 0) begin
                    ka = wq.pop_front(); kd = dq.pop_front(); mem[ka] = kd;
                end
                if (outst > max_outst) max_outst = outst;
            end
            #1;
            rdata_valid = !user_rst && rq.size() > 0 && rdue[0] <= cyc;
            rdata_data  = '0;
            if (rdata_valid && mem.exists(rq[0])) rdata_data = mem[rq[0]];
            if (rdata_valid && flip_en && rq[0] == flip_addr) rdata_data[0] = ~rdata_data[0];
            cmd_ready   = !(cmd_valid && cmd_we) || cmd_wait >= cmd_stall;
            wdata_ready = !wdata_valid || wd_wait >= wd_stall;
            if (!user_rst && busy && !cmd_we && outst == 8 && !cmd_valid) saw_limit = 1;
        end
    end

    task automatic clear_stats();
        wlog.delete(); rlog.delete(); mem.delete();
        n_wcmd = 0; n_wdata = 0; n_ret = 0; n_cv = 0; max_outst = 0;
        drop_err = 0; be_err = 0; saw_limit = 0;
    endtask

    task automatic start_run(input logic [23:0] b, input logic [23:0] c, input logic [15:0] s);
        @(posedge user_clk); #1;
        base_addr = b; word_count = c; seed = s; start = 1'b1;
        @(posedge user_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin
            @(posedge user_clk); #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done=%0b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge user_clk);
        #1;
        checks++;
        if ({busy, done, pass, first_err_valid, cmd_valid, cmd_we, wdata_valid, rdata_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: flags=%b required 00000000",
                     {busy, done, pass, first_err_valid, cmd_valid, cmd_we, wdata_valid, rdata_ready});
        end
        checks++;
        if ({error_count, first_err_addr, cmd_addr, wdata_we} !== '0) begin
            errors++;
            $display("FAIL reset_regs: err=%h ferr=%h addr=%h we=%h required all 0",
                     error_count, first_err_addr, cmd_addr, wdata_we);
        end
        checks++;
        if (wdata_data !== '0) begin errors++; $display("FAIL reset_wdata: %h required 0", wdata_data); end
        #2 user_rst = 1'b0;
    endtask

    task automatic test_ideal();
        logic [255:0] w;
        clear_stats(); lat = 1; cmd_stall = 0; wd_stall = 0; flip_en = 0;
        start_run(24'h10, 24'd8, 16'hA5A5);
        wait_done("ideal_done");
        checks++;
        if (pass !== 1'b1 || error_count !== 32'd0 || first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL ideal_result: pass=%b err=%0d fev=%b required 1/0/0", pass, error_count, first_err_valid);
        end
        checks++;
        if (n_wcmd != 8 || n_wdata != 8 || rlog.size() != 8) begin
            errors++;
            $display("FAIL ideal_counts: wcmd=%0d wdata=%0d rcmd=%0d required 8/8/8", n_wcmd, n_wdata, rlog.size());
        end
        w = mem[24'h10];
        checks++;
        if (w[15:0] !== 16'hA5B5) begin errors++; $display("FAIL ideal_lane0: %h required a5b5", w[15:0]); end
        w = mem[24'h17];
        checks++;
        if (w[255:240] !== 16'hA583) begin errors++; $display("FAIL ideal_lane15: %h required a583", w[255:240]); end
        checks++;
        if (wlog[0] !== 24'h10 || wlog[7] !== 24'h17 || rlog[0] !== 24'h10 || rlog[7] !== 24'h17) begin
            errors++;
            $display("FAIL ideal_addrs: w0=%h w7=%h r0=%h r7=%h required 10/17/10/17", wlog[0], wlog[7], rlog[0], rlog[7]);
        end
    endtask

    task automatic test_mismatch();
        clear_stats(); flip_en = 1; flip_addr = 24'h13;
        start_run(24'h10, 24'd8, 16'hA5A5);
        wait_done("mismatch_done");
        repeat (3) @(posedge user_clk);
        #1;
        checks++;
        if (error_count !== 32'd1) begin errors++; $display("FAIL mismatch_count: %0d required 1", error_count); end
        checks++;
        if (first_err_addr !== 24'h13 || first_err_valid !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_first: addr=%h valid=%b required 13/1", first_err_addr, first_err_valid);
        end
        checks++;
        if (pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_pass: pass=%b done=%b required 0/1", pass, done);
        end
        flip_en = 0;
    endtask

    task automatic test_stall();
        for (int r = 0; r < 2; r++) begin
            clear_stats(); lat = 1;
            cmd_stall = r == 0 ? 3 : 0;
            wd_stall  = r == 0 ? 0 : 3;
            start_run(24'h40, 24'd8, 16'h0F0F);
            repeat (3) @(posedge user_clk);
            #1;
            start = 1'b1; word_count = 24'd0;
            @(posedge user_clk); #1;
            start = 1'b0;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_start_r%0d: busy=%b required 1", r, busy); end
            wait_done("stall_done");
            checks++;
            if (n_wcmd != 8 || n_wdata != 8 || drop_err != 0 || be_err != 0) begin
                errors++;
                $display("FAIL stall_r%0d: wcmd=%0d wdata=%0d drop=%0d be=%0d required 8/8/0/0",
                         r, n_wcmd, n_wdata, drop_err, be_err);
            end
            checks++;
            if (wlog[0] !== 24'h40 || wlog[7] !== 24'h47 || pass !== 1'b1) begin
                errors++;
                $display("FAIL stall_seq_r%0d: w0=%h w7=%h pass=%b required 40/47/1", r, wlog[0], wlog[7], pass);
            end
        end
        cmd_stall = 0; wd_stall = 0;
    endtask

    task automatic test_outstanding();
        clear_stats(); lat = 20;
        start_run(24'h100, 24'd32, 16'h3C3C);
        wait_done("outst_done");
        checks++;
        if (max_outst > 8 || saw_limit != 1) begin
            errors++;
            $display("FAIL outst_limit: max=%0d limit_seen=%0d required <=8/1", max_outst, saw_limit);
        end
        checks++;
        if (n_ret != 32 || pass !== 1'b1 || error_count !== 32'd0) begin
            errors++;
            $display("FAIL outst_result: returns=%0d pass=%b err=%0d required 32/1/0", n_ret, pass, error_count);
        end
        lat = 1;
    endtask

    task automatic test_wrap();
        logic [23:0]  exp_a[4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        logic [255:0] w;
        clear_stats(); lat = 1;
        start_run(24'hFFFFFE, 24'd4, 16'h1234);
        wait_done("wrap_done");
        checks++;
        if (wlog.size() != 4 || rlog.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts: w=%0d r=%0d required 4/4", wlog.size(), rlog.size());
        end
        for (int i = 0; i < 4 && i < wlog.size() && i < rlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_a[i] || rlog[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: w=%h r=%h required %h", i, wlog[i], rlog[i], exp_a[i]);
            end
        end
        w = mem[24'h000000];
        checks++;
        if (w[15:0] !== 16'h1234) begin errors++; $display("FAIL wrap_lane0_0: %h required 1234", w[15:0]); end
        w = mem[24'hFFFFFF];
        checks++;
        if (w[15:0] !== 16'hEDCB) begin errors++; $display("FAIL wrap_lane0_ffffff: %h required edcb", w[15:0]); end
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL wrap_pass: %b required 1", pass); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_stats(); lat = 20;
        start_run(24'h200, 24'd32, 16'h5555);
        while (!(busy && !cmd_we && outst == 3) && n < 1000) begin
            @(posedge user_clk); #1;
            n++;
        end
        checks++;
        if (outst != 3) begin errors++; $display("FAIL rstmid_reach: outstanding=%0d required 3", outst); end
        #2 user_rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, first_err_valid, cmd_valid, cmd_we, wdata_valid, rdata_ready} !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_ctrl: flags=%b required 00000000",
                     {busy, done, pass, first_err_valid, cmd_valid, cmd_we, wdata_valid, rdata_ready});
        end
        checks++;
        if ({error_count, first_err_addr, cmd_addr, wdata_we} !== '0 || wdata_data !== '0) begin
            errors++;
            $display("FAIL rstmid_regs: err=%h ferr=%h addr=%h we=%h required all 0",
                     error_count, first_err_addr, cmd_addr, wdata_we);
        end
        @(posedge user_clk);
        #3 user_rst = 1'b0;
        n_cv = 0; lat = 1;
        start_run(24'h300, 24'd0, 16'h0000);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL zero_count: done=%b pass=%b required 1/1", done, pass);
        end
        repeat (3) @(posedge user_clk);
        #1;
        checks++;
        if (n_cv != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_count_idle: cmd_valid cycles=%0d done=%b required 0/1", n_cv, done);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_mismatch();
        test_stall();
        test_outstanding();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
